// File: rtl/sprite_compositor_if.sv
// Pixel-coordinate, object-state and composited-output bundle for sprite_compositor.
// Signal names match the original flat port list.
interface sprite_compositor_if;
  logic [8:0]  frame_x_2;
  logic [8:0]  frame_y_2;
  logic        new_frame_next;
  logic [8:0]  player_x;
  logic [8:0]  player_y;
  logic        player_alive;
  logic [8:0]  proj_x;
  logic [8:0]  proj_y;
  logic        proj_valid;
  logic [17:0] bg_color;
  logic [17:0] pixel_data;
  logic        hit_pulse;

  modport master (
    output frame_x_2, frame_y_2, new_frame_next,
    output player_x, player_y, player_alive,
    output proj_x, proj_y, proj_valid, bg_color,
    input  pixel_data, hit_pulse
  );

  modport slave (
    input  frame_x_2, frame_y_2, new_frame_next,
    input  player_x, player_y, player_alive,
    input  proj_x, proj_y, proj_valid, bg_color,
    output pixel_data, hit_pulse
  );
endinterface

// File: rtl/sprite_compositor.sv
// Two-stage player/projectile compositor with per-frame overlap pulse.
// Optional COLLISION_FLASH_EN: player flashes white for 7 frames after a hit.
module sprite_compositor (
  input  logic              clk_mhz_25,
  input  logic              resetn,
  sprite_compositor_if.slave bus
);

  logic [8:0]  sh_player_x, sh_player_y, sh_proj_x, sh_proj_y;
  logic        sh_player_alive, sh_proj_valid;
  logic [17:0] sh_bg_color;

  logic [8:0]  eff_player_x, eff_player_y, eff_proj_x, eff_proj_y;
  logic        eff_player_alive, eff_proj_valid;
  logic [17:0] eff_bg_color;

  logic [9:0]  x10, y10;
  logic        vis, player_hit, proj_hit;

  logic        s1_vis, s1_player, s1_proj;
  logic [17:0] s1_bg;
  logic        overlap_acc;
  logic [17:0] player_rgb;

  // Boundary cycle uses the live inputs so pixel (0,0) already sees the new frame.
  always_comb begin
    eff_player_x     = sh_player_x;
    eff_player_y     = sh_player_y;
    eff_player_alive = sh_player_alive;
    eff_proj_x       = sh_proj_x;
    eff_proj_y       = sh_proj_y;
    eff_proj_valid   = sh_proj_valid;
    eff_bg_color     = sh_bg_color;
    if (bus.new_frame_next) begin
      eff_player_x     = bus.player_x;
      eff_player_y     = bus.player_y;
      eff_player_alive = bus.player_alive;
      eff_proj_x       = bus.proj_x;
      eff_proj_y       = bus.proj_y;
      eff_proj_valid   = bus.proj_valid;
      eff_bg_color     = bus.bg_color;
    end
  end

  always_comb begin
    x10 = {1'b0, bus.frame_x_2};
    y10 = {1'b0, bus.frame_y_2};
    vis = (bus.frame_x_2 < 9'd320) && (bus.frame_y_2 < 9'd240);
    player_hit = eff_player_alive && vis &&
                 (x10 >= {1'b0, eff_player_x}) && (x10 <= {1'b0, eff_player_x} + 10'd7) &&
                 (y10 >= {1'b0, eff_player_y}) && (y10 <= {1'b0, eff_player_y} + 10'd7);
    proj_hit   = eff_proj_valid && vis &&
                 (x10 >= {1'b0, eff_proj_x}) && (x10 <= {1'b0, eff_proj_x} + 10'd3) &&
                 (y10 >= {1'b0, eff_proj_y}) && (y10 <= {1'b0, eff_proj_y} + 10'd3);
  end

  always_ff @(posedge clk_mhz_25 or negedge resetn) begin
    if (!resetn) begin
      sh_player_x     <= '0;
      sh_player_y     <= '0;
      sh_player_alive <= 1'b0;
      sh_proj_x       <= '0;
      sh_proj_y       <= '0;
      sh_proj_valid   <= 1'b0;
      sh_bg_color     <= '0;
    end else if (bus.new_frame_next) begin
      sh_player_x     <= bus.player_x;
      sh_player_y     <= bus.player_y;
      sh_player_alive <= bus.player_alive;
      sh_proj_x       <= bus.proj_x;
      sh_proj_y       <= bus.proj_y;
      sh_proj_valid   <= bus.proj_valid;
      sh_bg_color     <= bus.bg_color;
    end
  end

  always_ff @(posedge clk_mhz_25 or negedge resetn) begin
    if (!resetn) begin
      s1_vis    <= 1'b0;
      s1_player <= 1'b0;
      s1_proj   <= 1'b0;
      s1_bg     <= '0;
    end else begin
      s1_vis    <= vis;
      s1_player <= player_hit;
      s1_proj   <= proj_hit;
      s1_bg     <= eff_bg_color;
    end
  end

  always_ff @(posedge clk_mhz_25 or negedge resetn) begin
    if (!resetn) begin
      bus.pixel_data <= '0;
    end else if (s1_proj) begin
      bus.pixel_data <= 18'h3FFC0;
    end else if (s1_player) begin
      bus.pixel_data <= player_rgb;
    end else if (s1_vis) begin
      bus.pixel_data <= s1_bg;
    end else begin
      bus.pixel_data <= '0;
    end
  end

  // On the boundary the accumulator restarts with the (0,0) overlap, seen one stage early.
  always_ff @(posedge clk_mhz_25 or negedge resetn) begin
    if (!resetn) begin
      overlap_acc   <= 1'b0;
      bus.hit_pulse <= 1'b0;
    end else if (bus.new_frame_next) begin
      bus.hit_pulse <= overlap_acc;
      overlap_acc   <= player_hit && proj_hit;
    end else begin
      bus.hit_pulse <= 1'b0;
      if (s1_player && s1_proj) overlap_acc <= 1'b1;
    end
  end

`ifdef COLLISION_FLASH_EN
  logic [2:0] flash_cnt;

  always_ff @(posedge clk_mhz_25 or negedge resetn) begin
    if (!resetn) begin
      flash_cnt <= '0;
    end else if (bus.new_frame_next) begin
      if (overlap_acc) flash_cnt <= 3'd7;
      else if (flash_cnt != '0) flash_cnt <= flash_cnt - 3'd1;
    end
  end

  always_comb player_rgb = (flash_cnt != '0) ? 18'h3FFFF : 18'h3F410;
`else
  always_comb player_rgb = 18'h3F410;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Randomized self-checking bench for sprite_compositor against a frame-level model.
module tb_sprite_compositor;
  logic clk_mhz_25 = 1'b0;
  logic resetn;
  always #5 clk_mhz_25 = ~clk_mhz_25;

  sprite_compositor_if bus();
  sprite_compositor dut (.clk_mhz_25(clk_mhz_25), .resetn(resetn), .bus(bus));

  int checks = 0;
  int failures = 0;

  // Model state: object set of the current frame, frame overlap flag, flash frames left.
  int          fr_px, fr_py, fr_qx, fr_qy;
  bit          fr_alive, fr_valid;
  logic [17:0] fr_bg;
  bit          frame_ov;
  int          flash;
  logic [17:0] exp_prev;
  string       prev_tag;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit visible(int x, int y);
    return (x < 320) && (y < 240);
  endfunction

  function automatic bit in_box(int x, int y, int bx, int by, int sz);
    return (x >= bx) && (x < bx + sz) && (y >= by) && (y < by + sz);
  endfunction

  function automatic bit p_hit(int x, int y);
    return fr_alive && visible(x, y) && in_box(x, y, fr_px, fr_py, 8);
  endfunction

  function automatic bit q_hit(int x, int y);
    return fr_valid && visible(x, y) && in_box(x, y, fr_qx, fr_qy, 4);
  endfunction

  function automatic logic [17:0] model_pix(int x, int y);
    if (q_hit(x, y)) return 18'h3FFC0;
    if (p_hit(x, y)) return (flash > 0) ? 18'h3FFFF : 18'h3F410;
    if (visible(x, y)) return fr_bg;
    return 18'h0;
  endfunction

  task automatic model_reset();
    fr_px = 0; fr_py = 0; fr_qx = 0; fr_qy = 0;
    fr_alive = 0; fr_valid = 0; fr_bg = '0;
    frame_ov = 0; flash = 0; exp_prev = '0; prev_tag = "reset";
  endtask

  task automatic pixel(input int x, input int y, input bit nf, input string tag);
    logic [17:0] e;
    bit exp_hit;
    bus.frame_x_2      = 9'(x);
    bus.frame_y_2      = 9'(y);
    bus.new_frame_next = nf;
    exp_hit = 1'b0;
    if (nf) begin
      exp_hit = frame_ov;
`ifdef COLLISION_FLASH_EN
      if (frame_ov) flash = 7;
      else if (flash > 0) flash--;
`endif
      fr_px = int'(bus.player_x); fr_py = int'(bus.player_y); fr_alive = bus.player_alive;
      fr_qx = int'(bus.proj_x);   fr_qy = int'(bus.proj_y);   fr_valid = bus.proj_valid;
      fr_bg = bus.bg_color;
      frame_ov = 0;
    end
    e = model_pix(x, y);
    if (p_hit(x, y) && q_hit(x, y)) frame_ov = 1;
    @(posedge clk_mhz_25); #1;
    check(prev_tag, {14'b0, bus.pixel_data}, {14'b0, exp_prev});
    check(nf ? "hit_boundary" : "hit_idle", {31'b0, bus.hit_pulse}, {31'b0, exp_hit});
    exp_prev = e;
    prev_tag = tag;
  endtask

  // A blanking sample always precedes the boundary, as with real VGA timing.
  task automatic end_frame();
    pixel(399, 262, 1'b0, "blank");
    pixel(0, 0, 1'b1, "origin");
  endtask

  task automatic set_objects(input int px, input int py, input bit pa,
                             input int qx, input int qy, input bit qv);
    bus.player_x = 9'(px); bus.player_y = 9'(py); bus.player_alive = pa;
    bus.proj_x   = 9'(qx); bus.proj_y   = 9'(qy); bus.proj_valid   = qv;
  endtask

  task automatic do_reset(input int n);
    resetn = 1'b0;
    bus.new_frame_next = 1'b0;
    #1;
    check("rst_pix_async", {14'b0, bus.pixel_data}, 32'h0);
    check("rst_hit_async", {31'b0, bus.hit_pulse}, 32'h0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_mhz_25); #1;
      check("rst_pix", {14'b0, bus.pixel_data}, 32'h0);
      check("rst_hit", {31'b0, bus.hit_pulse}, 32'h0);
    end
    resetn = 1'b1;
    model_reset();
  endtask

  initial begin
    resetn = 1'b0;
    bus.frame_x_2 = '0; bus.frame_y_2 = '0; bus.new_frame_next = 1'b0;
    bus.bg_color = '0;
    set_objects(0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk_mhz_25); #1;
    do_reset(3);

    // Latency and blanking
    bus.bg_color = 18'h00ABC;
    end_frame();
    pixel(5, 5, 0, "lat_bg");
    pixel(330, 5, 0, "lat_blank_x");
    pixel(5, 250, 0, "lat_blank_y");

    // Priority
    set_objects(10, 10, 1, 12, 12, 1);
    end_frame();
    pixel(13, 13, 0, "prio_proj");
    pixel(10, 10, 0, "prio_player");
    pixel(18, 10, 0, "prio_bg");
    pixel(17, 17, 0, "prio_player_corner");
    pixel(15, 15, 0, "prio_proj_corner");
    pixel(16, 16, 0, "prio_player_edge");

    // Shadow capture; this frame overlapped so its boundary pulses
    bus.player_x = 9'd50;
    pixel(10, 10, 0, "shadow_old_player");
    pixel(50, 10, 0, "shadow_old_bg");
    end_frame();
    pixel(10, 10, 0, "shadow_new_bg");
    pixel(50, 10, 0, "shadow_new_player");
    end_frame();

    // Clipping at the visible edge
    set_objects(316, 236, 1, 0, 0, 0);
    end_frame();
    pixel(319, 239, 0, "clip_corner");
    pixel(320, 239, 0, "clip_x");
    pixel(316, 240, 0, "clip_y");
    pixel(318, 237, 0, "clip_inside");
    // Overlap only in blanking must not pulse
    set_objects(348, 10, 1, 350, 10, 1);
    end_frame();
    pixel(350, 10, 0, "blank_overlap");
    pixel(352, 12, 0, "blank_overlap2");
    end_frame();

    // Reset during an overlapping frame
    set_objects(10, 10, 1, 12, 12, 1);
    end_frame();
    pixel(12, 12, 0, "pre_reset_overlap");
    do_reset(3);
    pixel(12, 12, 0, "post_reset_a");
    pixel(13, 13, 0, "post_reset_b");
    end_frame();

    // One hit then several frames to observe the flash window
    pixel(12, 12, 0, "flash_hit");
    end_frame();
    bus.proj_valid = 1'b0;
    for (int f = 0; f < 9; f++) begin
      pixel(10, 10, 0, "flash_player");
      end_frame();
    end

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      set_objects($urandom_range(0, 340), $urandom_range(0, 250), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 340), $urandom_range(0, 250), $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) bus.proj_x = 9'(int'(bus.player_x) + $urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) bus.proj_y = 9'(int'(bus.player_y) + $urandom_range(0, 7));
      bus.bg_color = 18'($urandom);
      end_frame();
      for (int s = 0; s < 40; s++) begin
        int x, y;
        if ($urandom_range(0, 1) == 1) begin
          x = fr_px + $urandom_range(0, 9) - 1;
          y = fr_py + $urandom_range(0, 9) - 1;
          if (x < 0) x = 0;
          if (y < 0) y = 0;
        end else begin
          x = $urandom_range(0, 399);
          y = $urandom_range(0, 262);
        end
        if (s == 20) begin
          bus.player_x = 9'($urandom_range(0, 340));
          bus.bg_color = 18'($urandom);
        end
        pixel(x, y, 0, "rand");
      end
    end
    end_frame();
    pixel(0, 1, 0, "flush_a");
    pixel(0, 2, 0, "flush_b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sprite_compositor.md
SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 clk_mhz_25  input  1  pixel clock, the same 25 MHz clock that drives the VGA timing; all state changes on its rising edge.
REQ-002 resetn  input  1  reset, asynchronous, active-low.
REQ-003 frame_x_2  input  9  frame column, two cycles ahead of the displayed pixel; range 0..399.
REQ-004 frame_y_2  input  9  frame row, two cycles ahead of the displayed pixel; range 0..262.
REQ-005 new_frame_next  input  1  one-cycle frame-boundary pulse; in that cycle frame_x_2/frame_y_2 = (0,0).
REQ-006 player_x, player_y  input  9 each  top-left corner of the 8x8 player box.
REQ-007 player_alive  input  1  player box is drawn and collidable.
REQ-008 proj_x, proj_y  input  9 each  top-left corner of the 4x4 projectile box.
REQ-009 proj_valid  input  1  projectile box is drawn and collidable.
REQ-010 bg_color  input  18  background colour, {R6,G6,B6}.
REQ-011 pixel_data  output  18  composited colour for the displayed pixel, {R6,G6,B6}.
REQ-012 hit_pulse  output  1  one-cycle pulse: the frame just completed contained a player/projectile overlap.

Function
REQ-013 Object inputs (player_*, proj_*, bg_color) SHALL be captured into shadow registers on every edge where new_frame_next=1.
REQ-014 Effective object set SHALL be the live inputs when new_frame_next=1, otherwise the shadow registers; this makes pixel (0,0) use the new frame's values.
REQ-015 Visibility: vis = frame_x_2<320 && frame_y_2<240.
REQ-016 Player hit: player_alive && vis && player_x<=x<=player_x+7 && player_y<=y<=player_y+7.
REQ-017 Projectile hit: proj_valid && vis && proj_x<=x<=proj_x+3 && proj_y<=y<=proj_y+3.
REQ-018 Box bounds SHALL be computed at 10 bits, with no wrap; boxes extending past 319/239 are clipped.
REQ-019 Stage 1 SHALL register {vis, player hit, projectile hit} and the effective bg_color.
REQ-020 Stage 2 SHALL register pixel_data using a fixed priority:
- projectile 18'h3FFC0;
- otherwise player 18'h3F410;
- otherwise bg_color if vis;
- otherwise 0.
REQ-021 Latency SHALL be exactly 2 cycles from a frame_x_2/frame_y_2 sample to its pixel_data.
REQ-022 Overlap accumulator: set on any stage-1 cycle in which the player hit and the projectile hit are both 1.
REQ-023 On the edge where new_frame_next=1:
- hit_pulse <= accumulator value;
- accumulator <= the overlap of the current (0,0) pixel, so that pixel counts toward the new frame.
REQ-024 hit_pulse SHALL be 0 on every edge where new_frame_next=0.
REQ-025 Pixels in blanking (vis=0) SHALL never set the accumulator.

Reset
REQ-026 While resetn=0: pixel_data=0, hit_pulse=0, accumulator=0, all pipeline registers 0, all shadow registers 0.
REQ-027 Deassertion mid-frame: the pipeline refills within 2 cycles.
REQ-028 No hit_pulse SHALL be raised before the first full frame following a new_frame_next.

Configuration
REQ-029 With macro COLLISION_FLASH_EN defined:
- a 3-bit flash counter loads 7 when hit_pulse is set;
- it decrements on each new_frame_next while nonzero;
- while the counter is nonzero, player pixels SHALL be 18'h3FFFF instead of 18'h3F410.
REQ-030 Without COLLISION_FLASH_EN: no flash counter is instantiated; player pixels are always 18'h3F410.
REQ-031 The flash counter SHALL reset to 0.

Verification
REQ-032 Latency: bg_color=18'h00ABC, no objects; drive (5,5) at cycle N -> pixel_data=18'h00ABC at N+2; drive (330,5) -> 0.
REQ-033 Priority: player (10,10) alive, projectile (12,12) valid; drive (13,13) -> 18'h3FFC0, (10,10) -> 18'h3F410, (18,10) -> bg_color.
REQ-034 Shadow capture: change player_x from 10 to 50 mid-frame -> (10,10) is still player until the next new_frame_next; from pixel (0,0) of the new frame onward, player is drawn at 50.
REQ-035 Collision: overlap at (12,12) in frame F -> hit_pulse=1 for exactly one cycle on the new_frame_next that closes F; with no overlap in F+1 -> 0 at the next boundary.
REQ-036 Clipping/blanking: player at (316,236) -> drawn only up to x=319, y=239; projectile at (350,10) with overlapping player -> no hit_pulse.
REQ-037 Reset mid-frame: resetn low for 3 cycles during an overlapping frame -> accumulator cleared, no hit_pulse at the next boundary; with COLLISION_FLASH_EN, the flash lasts 7 frames after one hit.
